// File: rtl/dma_capture_engine.sv
// dma_capture_engine
// Captures a qualified sample stream into a FIFO and writes it to memory as
// fixed-length AXI4 INCR bursts starting at BASE_ADDR. One capture is
// NUM_BURSTS bursts; bresp errors and FIFO overruns are reported as sticky
// status bits that clear when the next capture starts.
// Optional build macro: DMA_RING_MODE_EN -- the address wraps back to
// BASE_ADDR after the last burst and capture keeps running until stop_i is
// seen; the burst in progress then completes and the engine finishes.
module dma_capture_engine #(
  parameter int          DATA_W     = 64,
  parameter int          BURST_LEN  = 16,
  parameter int          NUM_BURSTS = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 32
) (
  input  logic                aclk,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                valid_i,
  output logic [31:0]         m_axi_awaddr,
  output logic [3:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic                m_axi_bvalid,
  input  logic [1:0]          m_axi_bresp,
  output logic                m_axi_bready,
  output logic                busy_o,
  output logic                finished_o,
  output logic                overflow_o,
  output logic                error_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [31:0]       BURST_BYTES = 32'(BURST_LEN * STRB_W);
  localparam logic [31:0]       LAST_BURST  = 32'(NUM_BURSTS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  BURST_CNT   = CNT_W'(BURST_LEN);
  localparam logic [2:0]        AW_SIZE     = 3'($clog2(STRB_W));

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FILL = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];

  logic [2:0]        state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [31:0]       burst_q, burst_d;
  logic [31:0]       addr_q, addr_d;
  logic              overflow_q, overflow_d;
  logic              error_q, error_d;
  logic              awvalid_q, wvalid_q, wlast_q, bready_q, busy_q, finished_q;

  logic              start_s, capture_s, full_s, push_s, pop_s, last_burst_s;
  logic              end_capture_s;

`ifdef DMA_RING_MODE_EN
  logic              stop_q, stop_d;

  // Samples are taken until stop is latched; the burst still filling keeps collecting.
  assign capture_s = (state_q != ST_IDLE) && (state_q != ST_DONE) &&
                     (!stop_q || (state_q == ST_FILL));
  // Finish after the current B once stop has been seen (including this cycle).
  assign end_capture_s = stop_q | stop_i;
`else
  logic [31:0]       accepted_q, accepted_d;
  logic              unused_stop_s;

  // Single shot: stop_i has no function in this build.
  assign unused_stop_s = stop_i;
  // Samples are taken until a full capture's worth has been accepted.
  assign capture_s = (state_q != ST_IDLE) && (state_q != ST_DONE) &&
                     (accepted_q < 32'(NUM_BURSTS * BURST_LEN));
  assign end_capture_s = last_burst_s;
`endif

  assign start_s      = (state_q == ST_IDLE) && start_i;
  assign full_s       = (count_q == FULL_CNT);
  assign push_s       = capture_s && valid_i && !full_s;
  assign pop_s        = wvalid_q && m_axi_wready;
  assign last_burst_s = (burst_q == LAST_BURST);

  // Next-state and datapath update for FSM, FIFO pointers, counters and status.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    beat_d     = beat_q;
    burst_d    = burst_q;
    addr_d     = addr_q;
    overflow_d = overflow_q;
    error_d    = error_q;
`ifdef DMA_RING_MODE_EN
    stop_d     = stop_q;
`else
    accepted_d = accepted_q;
`endif
    if (start_s) begin
      // A new capture starts from a clean FIFO and clean status.
      state_d    = ST_FILL;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      beat_d     = '0;
      burst_d    = 32'd0;
      addr_d     = BASE_ADDR;
      overflow_d = 1'b0;
      error_d    = 1'b0;
`ifdef DMA_RING_MODE_EN
      stop_d     = 1'b0;
`else
      accepted_d = 32'd0;
`endif
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
`ifndef DMA_RING_MODE_EN
        accepted_d = accepted_q + 32'd1;
`endif
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      // A sample arriving at a full FIFO is lost, even if a pop happens this cycle.
      if (capture_s && valid_i && full_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        beat_d   = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
        beat_d   = beat_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
`ifdef DMA_RING_MODE_EN
      if ((state_q != ST_IDLE) && stop_i) begin
        stop_d = 1'b1;
      end else begin
        stop_d = stop_q;
      end
`endif
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_FILL: begin
          if (count_q >= BURST_CNT) begin
            state_d = ST_ADDR;
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_ADDR: begin
          if (m_axi_awready) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_DATA: begin
          if (pop_s && (beat_q == LAST_BEAT)) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_RESP: begin
          if (m_axi_bvalid) begin
            if (m_axi_bresp != 2'b00) begin
              error_d = 1'b1;
            end else begin
              error_d = error_q;
            end
`ifdef DMA_RING_MODE_EN
            if (last_burst_s) begin
              addr_d  = BASE_ADDR;
              burst_d = 32'd0;
            end else begin
              addr_d  = addr_q + BURST_BYTES;
              burst_d = burst_q + 32'd1;
            end
`else
            addr_d  = addr_q + BURST_BYTES;
            burst_d = burst_q + 32'd1;
`endif
            state_d = end_capture_s ? ST_DONE : ST_FILL;
          end else begin
            state_d = ST_RESP;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counters, status and registered AXI/status outputs.
  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      burst_q    <= 32'd0;
      addr_q     <= BASE_ADDR;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      bready_q   <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
`ifdef DMA_RING_MODE_EN
      stop_q     <= 1'b0;
`else
      accepted_q <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      burst_q    <= burst_d;
      addr_q     <= addr_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
      awvalid_q  <= (state_d == ST_ADDR);
      wvalid_q   <= (state_d == ST_DATA);
      wlast_q    <= (state_d == ST_DATA) && (beat_d == LAST_BEAT);
      bready_q   <= (state_d == ST_RESP);
      busy_q     <= (state_d != ST_IDLE);
      finished_q <= (state_d == ST_DONE);
`ifdef DMA_RING_MODE_EN
      stop_q     <= stop_d;
`else
      accepted_q <= accepted_d;
`endif
    end
  end

  // Sample storage; contents need no reset since the pointers define validity.
  always_ff @(posedge aclk) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 4'(BURST_LEN - 1);
  assign m_axi_awsize  = AW_SIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = fifo_mem_q[rd_ptr_q];
  assign m_axi_wstrb   = {STRB_W{1'b1}};
  assign m_axi_wlast   = wlast_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign busy_o        = busy_q;
  assign finished_o    = finished_q;
  assign overflow_o    = overflow_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_dma_capture_engine.sv
// Scoreboard bench for dma_capture_engine (default build, single-shot mode).
// Stimulus pushes expected AW addresses and W beats into queues; a monitor
// pops and compares on every AXI handshake and checks stall stability.
module tb_dma_capture_engine;
  localparam int DW = 64;
  localparam int BL = 16;
  localparam int NB = 3;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic          aclk = 1'b0;
  logic          rst_i, start_i, stop_i, valid_i;
  logic [DW-1:0] data_i;
  logic [31:0]   m_axi_awaddr;
  logic [3:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_awvalid, m_axi_awready;
  logic [DW-1:0] m_axi_wdata;
  logic [7:0]    m_axi_wstrb;
  logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic          m_axi_bvalid, m_axi_bready;
  logic [1:0]    m_axi_bresp;
  logic          busy_o, finished_o, overflow_o, error_o;

  always #5 aclk = ~aclk;

  dma_capture_engine #(
    .DATA_W(DW), .BURST_LEN(BL), .NUM_BURSTS(NB), .BASE_ADDR(BASE), .FIFO_DEPTH(32)
  ) u_dut (
    .aclk(aclk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .data_i(data_i), .valid_i(valid_i),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
    .busy_o(busy_o), .finished_o(finished_o), .overflow_o(overflow_o), .error_o(error_o)
  );

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } wexp_t;

  logic [31:0] exp_aw[$];
  wexp_t       exp_w[$];
  int          checks = 0;
  int          errors = 0;
  int          fin_cnt = 0;
  int          w_hs_cnt = 0;
  int          aw_delay = 0;
  int          wr_mode = 0;
  int          b_delay = 1;
  int          b_idx = 0;
  int          vmode = 0;
  int          vk = 0;
  logic [63:0] dbase = 64'd0;
  logic [1:0]  bresp_tab [0:7];

  // monitor state
  logic        w_stall = 1'b0, aw_stall = 1'b0, sl = 1'b0;
  logic [63:0] sd = 64'd0;
  logic [31:0] sa = 32'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_aw(input int n);
    for (int b = 0; b < n; b++) exp_aw.push_back(BASE + 32'(b * BL * 8));
  endtask

  task automatic push_run(input logic [63:0] base, input int n);
    wexp_t e;
    for (int j = 0; j < n; j++) begin
      e.d = base + 64'(j);
      e.l = ((j % BL) == BL - 1);
      exp_w.push_back(e);
    end
  endtask

  task automatic new_test();
    @(posedge aclk); #2;
    fin_cnt  = 0;
    w_hs_cnt = 0;
    b_idx    = 0;
  endtask

  task automatic start_capture(input int vm, input logic [63:0] base);
    @(posedge aclk); #1;
    start_i = 1'b1;
    @(negedge aclk);
    vk    = 0;
    dbase = base;
    vmode = vm;
    @(posedge aclk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while (fin_cnt == 0 && n < budget) begin
      @(posedge aclk); #2;
      n++;
    end
    if (fin_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no finished_o within %0d cycles, expected one pulse", nm, budget);
    end
    repeat (3) begin @(posedge aclk); #2; end
    chk({nm, "_finished_pulses"}, 64'(fin_cnt), 64'd1);
    chk({nm, "_aw_left"}, 64'(exp_aw.size()), 64'd0);
    chk({nm, "_w_left"}, 64'(exp_w.size()), 64'd0);
    chk({nm, "_busy_idle"}, 64'(busy_o), 64'd0);
    @(negedge aclk);
    vmode = 0;
    exp_aw.delete();
    exp_w.delete();
  endtask

  // Sample source: one new value per valid cycle.
  initial begin
    forever begin
      @(posedge aclk); #1;
      if (valid_i) vk++;
      case (vmode)
        0:       valid_i = 1'b0;
        1:       valid_i = 1'b1;
        default: valid_i = ~valid_i;
      endcase
      data_i = dbase + 64'(vk);
    end
  end

  // AW slave: awready after aw_delay cycles of awvalid.
  initial begin
    int aw_cnt = 0;
    forever begin
      @(posedge aclk); #1;
      if (m_axi_awvalid === 1'b1) begin
        m_axi_awready = (aw_cnt >= aw_delay);
        aw_cnt++;
      end else begin
        m_axi_awready = 1'b0;
        aw_cnt = 0;
      end
    end
  end

  // W slave: ready pattern selected by wr_mode.
  initial begin
    int cyc = 0;
    forever begin
      @(posedge aclk); #1;
      cyc++;
      case (wr_mode)
        0:       m_axi_wready = 1'b1;
        1:       m_axi_wready = ((cyc % 4) != 0);
        default: m_axi_wready = 1'b0;
      endcase
    end
  end

  // B slave: response b_delay cycles after the last W beat.
  initial begin
    forever begin
      @(negedge aclk);
      if (!rst_i && m_axi_wvalid && m_axi_wready && m_axi_wlast) begin
        repeat (b_delay) @(posedge aclk);
        #1;
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = bresp_tab[b_idx % 8];
        do @(negedge aclk); while (m_axi_bready !== 1'b1);
        @(posedge aclk); #1;
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        b_idx++;
      end
    end
  end

  // Monitor: compare every handshake against the scoreboard queues.
  initial begin
    wexp_t e;
    logic [31:0] ea;
    forever begin
      @(negedge aclk);
      if (rst_i) begin
        w_stall  = 1'b0;
        aw_stall = 1'b0;
      end else begin
        if (finished_o) fin_cnt++;
        if (aw_stall && m_axi_awvalid) chk("awaddr_stable", 64'(m_axi_awaddr), 64'(sa));
        if (m_axi_awvalid && m_axi_awready) begin
          if (exp_aw.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_aw: got addr %h, expected no AW", m_axi_awaddr);
          end else begin
            ea = exp_aw.pop_front();
            chk("awaddr", 64'(m_axi_awaddr), 64'(ea));
            chk("awlen", 64'(m_axi_awlen), 64'd15);
            chk("awsize", 64'(m_axi_awsize), 64'd3);
            chk("awburst", 64'(m_axi_awburst), 64'd1);
          end
        end
        aw_stall = m_axi_awvalid && !m_axi_awready;
        sa       = m_axi_awaddr;
        if (w_stall && m_axi_wvalid) begin
          chk("wdata_stable", m_axi_wdata, sd);
          chk("wlast_stable", 64'(m_axi_wlast), 64'(sl));
        end
        if (m_axi_wvalid && m_axi_wready) begin
          w_hs_cnt++;
          if (exp_w.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_w: got data %h, expected no W beat", m_axi_wdata);
          end else begin
            e = exp_w.pop_front();
            chk("wdata", m_axi_wdata, e.d);
            chk("wlast", 64'(m_axi_wlast), 64'(e.l));
            chk("wstrb", 64'(m_axi_wstrb), 64'hFF);
          end
        end
        w_stall = m_axi_wvalid && !m_axi_wready;
        sd      = m_axi_wdata;
        sl      = m_axi_wlast;
      end
    end
  end

  // Global time limit.
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got no end of test, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit reached");
  end

  // Directed test sequence.
  initial begin
    int n;
    for (int i = 0; i < 8; i++) bresp_tab[i] = 2'b00;
    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; valid_i = 1'b0; data_i = 64'd0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    repeat (3) @(negedge aclk);
    chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
    chk("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
    chk("rst_wlast", 64'(m_axi_wlast), 64'd0);
    chk("rst_bready", 64'(m_axi_bready), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_finished", 64'(finished_o), 64'd0);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    chk("rst_error", 64'(error_o), 64'd0);
    @(posedge aclk); #1;
    rst_i = 1'b0;

    // 1: plain capture, extra start/stop while busy are ignored
    new_test();
    push_aw(NB);
    push_run(64'h1111_0000_0000_0000, NB * BL);
    start_capture(1, 64'h1111_0000_0000_0000);
    repeat (20) @(posedge aclk);
    #1; start_i = 1'b1; stop_i = 1'b1;
    @(posedge aclk); #1; start_i = 1'b0; stop_i = 1'b0;
    wait_done(400, "plain");
    chk("plain_overflow", 64'(overflow_o), 64'd0);
    chk("plain_error", 64'(error_o), 64'd0);

    // 2: AW/W/B stalls with sparse valid_i
    @(negedge aclk);
    aw_delay = 3; wr_mode = 1; b_delay = 3;
    new_test();
    push_aw(NB);
    push_run(64'h2222_0000_0000_0000, NB * BL);
    start_capture(2, 64'h2222_0000_0000_0000);
    wait_done(1500, "stall");
    chk("stall_overflow", 64'(overflow_o), 64'd0);

    // 3: wready held low -> FIFO fills at 32, later samples dropped
    @(negedge aclk);
    aw_delay = 0; wr_mode = 2; b_delay = 1;
    new_test();
    push_aw(NB);
    push_run(64'h3333_0000_0000_0000, 32);
    push_run(64'h3333_5555_0000_0000, 16);
    start_capture(1, 64'h3333_0000_0000_0000);
    repeat (44) @(negedge aclk);
    vmode = 0;
    wr_mode = 0;
    chk("ovf_set", 64'(overflow_o), 64'd1);
    repeat (4) @(negedge aclk);
    vk = 0;
    dbase = 64'h3333_5555_0000_0000;
    vmode = 1;
    wait_done(600, "ovf");
    chk("ovf_sticky", 64'(overflow_o), 64'd1);

    // 4: SLVERR on first burst; sequence continues; overflow cleared by start
    @(negedge aclk);
    bresp_tab[0] = 2'b10;
    new_test();
    push_aw(NB);
    push_run(64'h4444_0000_0000_0000, NB * BL);
    start_capture(1, 64'h4444_0000_0000_0000);
    wait_done(400, "err");
    chk("err_set", 64'(error_o), 64'd1);
    chk("err_ovf_cleared", 64'(overflow_o), 64'd0);
    bresp_tab[0] = 2'b00;

    // 5: reset at beat 5 of burst 1
    new_test();
    push_aw(1);
    push_run(64'h5555_0000_0000_0000, 5);
    start_capture(1, 64'h5555_0000_0000_0000);
    n = 0;
    while (w_hs_cnt < 5 && n < 300) begin
      @(posedge aclk); #2;
      n++;
    end
    chk("midrst_reached_beat5", 64'(w_hs_cnt), 64'd5);
    rst_i = 1'b1;
    #1;
    chk("midrst_awvalid", 64'(m_axi_awvalid), 64'd0);
    chk("midrst_wvalid", 64'(m_axi_wvalid), 64'd0);
    chk("midrst_wlast", 64'(m_axi_wlast), 64'd0);
    chk("midrst_bready", 64'(m_axi_bready), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_finished", 64'(finished_o), 64'd0);
    chk("midrst_error", 64'(error_o), 64'd0);
    repeat (2) @(posedge aclk);
    #1; rst_i = 1'b0;
    repeat (20) @(posedge aclk);
    #2;
    chk("midrst_no_more_beats", 64'(w_hs_cnt), 64'd5);
    chk("midrst_idle", 64'(busy_o), 64'd0);
    chk("midrst_aw_consumed", 64'(exp_aw.size()), 64'd0);
    @(negedge aclk);
    vmode = 0;
    exp_aw.delete();
    exp_w.delete();

    // 6: restart after reset begins at BASE with fresh data
    repeat (2) @(posedge aclk);
    new_test();
    push_aw(NB);
    push_run(64'h6666_0000_0000_0000, NB * BL);
    start_capture(1, 64'h6666_0000_0000_0000);
    wait_done(400, "restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_capture_engine.md
DMA_CAPTURE_ENGINE -- requirements
Module: dma_capture_engine

Interface
REQ-001 Parameter DATA_W, 64, sample/AXI data width in bits; SHALL be 32 or 64.
REQ-002 Parameter BURST_LEN, 16, beats per AXI burst; SHALL be 1..16.
REQ-003 Parameter NUM_BURSTS, 8, bursts per capture; SHALL be >=1.
REQ-004 Parameter BASE_ADDR, 32'h1000_0000, first burst byte address; SHALL be aligned to BURST_LEN*DATA_W/8.
REQ-005 Parameter FIFO_DEPTH, 32, sample FIFO entries; SHALL be a power of two and >= 2*BURST_LEN.
REQ-006 aclk  in  1  sole clock; all logic on rising edge.
REQ-007 rst_i  in  1  asynchronous, active-high reset.
REQ-008 start_i  in  1  single-cycle capture request.
REQ-009 stop_i  in  1  ring-mode stop request (ignored without DMA_RING_MODE_EN).
REQ-010 data_i / valid_i  in  DATA_W / 1  sample and qualifier.
REQ-011 m_axi_aw{addr,len,size,burst,valid}  out  32/4/3/2/1; m_axi_awready in 1.
REQ-012 m_axi_w{data,strb,last,valid}  out  DATA_W/DATA_W/8/1/1; m_axi_wready in 1.
REQ-013 m_axi_bvalid in 1, m_axi_bresp in 2, m_axi_bready out 1.
REQ-014 busy_o, finished_o, overflow_o, error_o  out  1 each  status.

Function
REQ-015 awlen SHALL be BURST_LEN-1, awsize log2(DATA_W/8), awburst 2'b01 (INCR), wstrb all ones, all constant.
REQ-016 FSM states: IDLE, FILL, ADDR, DATA, RESP, DONE.
REQ-017 IDLE->FILL on start_i; start_i while busy_o=1 SHALL be ignored; busy_o=1 in every state except IDLE.
REQ-018 While capturing, every valid_i=1 cycle SHALL push data_i into the FIFO until NUM_BURSTS*BURST_LEN samples are accepted.
REQ-019 Push with FIFO full SHALL drop the sample, not count it, and set sticky overflow_o.
REQ-020 FILL->ADDR when FIFO count >= BURST_LEN; awvalid asserted in ADDR, held with awaddr stable until awready.
REQ-021 ADDR->DATA on AW handshake; wvalid=1 in DATA, wdata = FIFO head; wdata/wlast SHALL be stable while wready=0.
REQ-022 FIFO pops only on wvalid&wready; wlast=1 on beat BURST_LEN-1 (0-based) only.
REQ-023 DATA->RESP after last beat; bready=1 in RESP only; RESP exits on bvalid.
REQ-024 bresp!=2'b00 SHALL set sticky error_o; the sequence continues.
REQ-025 After each B: address += BURST_LEN*DATA_W/8 (mod 2^32); next state FILL if bursts remain, else DONE.
REQ-026 DONE SHALL assert finished_o for exactly one cycle, then go to IDLE.
REQ-027 Simultaneous FIFO push and pop SHALL leave count unchanged; full and empty flags derived from count.
REQ-028 overflow_o and error_o SHALL clear on accepted start_i.

Reset
REQ-029 rst_i SHALL asynchronously force IDLE, clear FIFO and counters, address to BASE_ADDR.
REQ-030 During reset all AXI valid/ready outputs, wlast, busy_o, finished_o, overflow_o, error_o SHALL be 0.
REQ-031 Reset mid-burst SHALL abandon the transaction; no further AXI activity until the next start_i.

Configuration
REQ-032 Macro DMA_RING_MODE_EN defined: after the last burst's B, address SHALL wrap to BASE_ADDR and capture continues (FILL) until stop_i seen; stop_i latches and the current burst completes, then DONE.
REQ-033 Macro DMA_RING_MODE_EN undefined: single-shot capture of NUM_BURSTS bursts; stop_i has no effect.

Verification
REQ-034 DATA_W=64,BURST_LEN=16,NUM_BURSTS=2, valid_i=1, ready always 1, bresp OKAY -> awaddr 0x1000_0000 then 0x1000_0080, 32 beats in order, wlast on beats 16 and 32, one finished_o pulse.
REQ-035 awready low 3 cycles, wready low every 4th cycle, B delayed 3 cycles -> same data order, wdata stable during every stall, one finished_o.
REQ-036 wready held 0 for 40 cycles with valid_i=1 -> overflow_o=1 after FIFO holds 32, dropped samples absent from written data.
REQ-037 bresp=2'b10 on burst 1 -> error_o=1, burst 2 still issued at 0x1000_0080, finished_o pulses.
REQ-038 rst_i pulsed at beat 5 of burst 1 -> all outputs 0 immediately; next start_i restarts at 0x1000_0000.
REQ-039 DMA_RING_MODE_EN, NUM_BURSTS=2, stop_i during burst 4 -> addresses 0x..00,0x..80,0x..00,0x..80, then finished_o.
